// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between a registered-read FIFO and its drain stage.
//   fifo_empty   : FIFO empty flag (driven by the FIFO)
//   fifo_rd_data : read data, valid the cycle after fifo_pop (driven by the FIFO)
//   fifo_pop     : pop request (driven by the drain stage)
// The master modport is the side that issues pops; the slave modport is the FIFO.
interface fifo_uart_tx_if #(
    parameter int DATA_W = 8
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_pop;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        output fifo_pop
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        input  fifo_pop
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a registered-read FIFO one word at a time and sends each
// word as a UART frame: start bit, DATA_W data bits LSB first, optional even
// parity bit, one stop bit. The line idles high.
// Ports:
//   clk        : clock
//   rst        : asynchronous active-high reset
//   en         : 1 = allowed to start new frames
//   fifo       : FIFO read port (master side: pop out, empty/rd_data in)
//   tx         : serial line output (registered)
//   busy       : 1 while a frame is in progress
//   frame_done : one-cycle pulse after each completed frame
module fifo_uart_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    fifo_uart_tx_if.master        fifo,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_PARITY = 3'd4;
    localparam logic [2:0] S_STOP   = 3'd5;

    logic [2:0]        state_reg;
    logic [BAUD_W-1:0] baud_cnt_reg;
    logic [BIT_W-1:0]  bit_cnt_reg;
    logic [DATA_W-1:0] shreg_reg;
    logic              parity_reg;
    logic              tx_reg;
    logic              frame_done_reg;

    logic              bit_end;
    logic [DATA_W-1:0] shreg_shifted;

    assign bit_end       = (baud_cnt_reg == BAUD_LAST);
    assign shreg_shifted = shreg_reg >> 1;

    // Pop only from IDLE, so a frame can never consume more than one word.
    // rst is included so no pop leaks out while reset is held.
    assign fifo.fifo_pop = (state_reg == S_IDLE) && en && !fifo.fifo_empty && !rst;

    assign tx         = tx_reg;
    assign busy       = (state_reg != S_IDLE);
    assign frame_done = frame_done_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            baud_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            shreg_reg      <= '0;
            parity_reg     <= 1'b0;
            tx_reg         <= 1'b1;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    tx_reg       <= 1'b1;
                    baud_cnt_reg <= '0;
                    if (fifo.fifo_pop) begin
                        state_reg <= S_LOAD;
                    end
                end
                // Read data arrives this cycle (one after the pop); capture it
                // and launch the start bit on the same edge.
                S_LOAD: begin
                    shreg_reg    <= fifo.fifo_rd_data;
                    parity_reg   <= ^fifo.fifo_rd_data;
                    tx_reg       <= 1'b0;
                    baud_cnt_reg <= '0;
                    state_reg    <= S_START;
                end
                S_START: begin
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        bit_cnt_reg  <= '0;
                        tx_reg       <= shreg_reg[0];
                        state_reg    <= S_DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
                    end
                end
                // tx already holds shreg[0]; at each boundary the register
                // shifts and the next LSB is loaded into tx together.
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        if (bit_cnt_reg == BIT_LAST) begin
                            if (PARITY_EN != 0) begin
                                tx_reg    <= parity_reg;
                                state_reg <= S_PARITY;
                            end else begin
                                tx_reg    <= 1'b1;
                                state_reg <= S_STOP;
                            end
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                            shreg_reg   <= shreg_shifted;
                            tx_reg      <= shreg_shifted[0];
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        tx_reg       <= 1'b1;
                        state_reg    <= S_STOP;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        baud_cnt_reg   <= '0;
                        frame_done_reg <= 1'b1;
                        state_reg      <= S_IDLE;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
                    end
                end
                default: begin
                    tx_reg    <= 1'b1;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end
endmodule
